// File: rtl/serdes_pkg.sv
// Shared constants and types for the 8b/10b serial transmitter.
// K28.5 codes are stored in [9:0] = a b c d e i f g h j order.
package serdes_pkg;

  localparam logic [7:0] K28_5  = 8'hBC;
  localparam int         CODE_W = 10;

  typedef enum logic {
    QUIET = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CODE_W-1:0] K28_5_RDN = 10'b0011111010;
  localparam logic [CODE_W-1:0] K28_5_RDP = 10'b1100000101;

endpackage

// File: rtl/encoder_8b10b.sv
// Combinational 8b/10b encoder (data or K28.5), zero latency, no flow control.
// 5b/6b and 3b/4b sub-blocks are held as their RD- form and inverted when the running disparity requires it.
module encoder_8b10b
  import serdes_pkg::*;
(
  input  logic [7:0]        data,
  input  logic              k,
  input  logic              rd_in,
  output logic [CODE_W-1:0] code,
  output logic              rd_out,
  output logic              k_err
);

  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] c6;
  logic [3:0] c4;
  logic       unbal6, unbal4, flip6, flip4, rd_mid, alt7;

  function automatic logic [5:0] sb6_rdn(input logic [4:0] v);
    logic [5:0] r;
    case (v)
      5'd0:  r = 6'b100111;  5'd1:  r = 6'b011101;
      5'd2:  r = 6'b101101;  5'd3:  r = 6'b110001;
      5'd4:  r = 6'b110101;  5'd5:  r = 6'b101001;
      5'd6:  r = 6'b011001;  5'd7:  r = 6'b111000;
      5'd8:  r = 6'b111001;  5'd9:  r = 6'b100101;
      5'd10: r = 6'b010101;  5'd11: r = 6'b110100;
      5'd12: r = 6'b001101;  5'd13: r = 6'b101100;
      5'd14: r = 6'b011100;  5'd15: r = 6'b010111;
      5'd16: r = 6'b011011;  5'd17: r = 6'b100011;
      5'd18: r = 6'b010011;  5'd19: r = 6'b110010;
      5'd20: r = 6'b001011;  5'd21: r = 6'b101010;
      5'd22: r = 6'b011010;  5'd23: r = 6'b111010;
      5'd24: r = 6'b110011;  5'd25: r = 6'b100110;
      5'd26: r = 6'b010110;  5'd27: r = 6'b110110;
      5'd28: r = 6'b001110;  5'd29: r = 6'b101110;
      5'd30: r = 6'b011110;  default: r = 6'b101011;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] sb4_rdn(input logic [2:0] v);
    logic [3:0] r;
    case (v)
      3'd0: r = 4'b1011;  3'd1: r = 4'b1001;
      3'd2: r = 4'b0101;  3'd3: r = 4'b1100;
      3'd4: r = 4'b1101;  3'd5: r = 4'b1010;
      3'd6: r = 4'b0110;  default: r = 4'b1110;
    endcase
    return r;
  endfunction

  always_comb begin
    x      = data[4:0];
    y      = data[7:5];
    c6     = k ? K28_5_RDN[9:4] : sb6_rdn(x);
    unbal6 = ($countones(c6) != 3);
    // D.7 is balanced but still alternates with disparity
    flip6  = rd_in && (unbal6 || (!k && x == 5'd7));
    rd_mid = unbal6 ? !rd_in : rd_in;

    // A7 avoids a run of five identical bits across the sub-block seam
    alt7   = !k && (y == 3'd7) &&
             (rd_mid ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                     : (x == 5'd17 || x == 5'd18 || x == 5'd20));
    c4     = k ? 4'b0101 : (alt7 ? 4'b0111 : sb4_rdn(y));
    unbal4 = ($countones(c4) != 2);
    flip4  = rd_mid && (unbal4 || k || y == 3'd3);

    code   = {c6 ^ {6{flip6}}, c4 ^ {4{flip4}}};
    rd_out = unbal4 ? !rd_mid : rd_mid;
    k_err  = k && (data != K28_5);
  end

endmodule

// File: rtl/serializer_enc.sv
// 8b/10b serial transmitter: a byte accepted now leaves at the next word boundary, j bit first.
// One-entry hold register; o_Ready is low while it is occupied (1 byte per 10 clocks sustained).
module serializer_enc
  import serdes_pkg::*;
#(
  parameter bit SEND_IDLE = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_En,
  input  logic       i_Valid,
  input  logic [7:0] i_Data,
  input  logic       i_K,
  output logic       o_Ready,
  output logic       o_Serial,
  output logic       o_Word_Start,
  output logic       o_RD,
  output logic       o_K_Err
);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [CODE_W-1:0] shift_q, shift_d;
  logic              rd_q, rd_d;
  logic              serial_q;
  logic              k_err_q, k_err_d;
  logic              hold_vld_q;
  logic [8:0]        hold_q;
  logic              accept, load, take;
  logic [CODE_W-1:0] enc_code;
  logic              enc_rd, enc_k_err;

  assign o_Ready = !hold_vld_q;
  assign accept  = i_Valid && !hold_vld_q;
  assign take    = load && hold_vld_q;

  encoder_8b10b u_enc (
    .data   (hold_q[7:0]),
    .k      (hold_q[8]),
    .rd_in  (rd_q),
    .code   (enc_code),
    .rd_out (enc_rd),
    .k_err  (enc_k_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    rd_d    = rd_q;
    k_err_d = 1'b0;
    load    = 1'b0;

    unique case (state_q)
      QUIET: begin
        cnt_d   = '0;
        shift_d = '0;
        load    = i_En;
      end
      SHIFT: begin
        // i_En is only looked at here, so a word is never cut short
        if (cnt_q == 4'd9) begin
          if (i_En) begin
            load = 1'b1;
          end else begin
            state_d = QUIET;
            cnt_d   = '0;
            shift_d = '0;
          end
        end else begin
          cnt_d   = cnt_q + 4'd1;
          shift_d = {1'b0, shift_q[CODE_W-1:1]};
        end
      end
    endcase

    if (load) begin
      state_d = SHIFT;
      cnt_d   = '0;
      if (hold_vld_q) begin
        shift_d = enc_code;
        rd_d    = enc_rd;
        k_err_d = enc_k_err;
      end else if (SEND_IDLE) begin
        // K28.5 is unbalanced overall, so idle always flips RD
        shift_d = rd_q ? K28_5_RDP : K28_5_RDN;
        rd_d    = !rd_q;
      end else begin
        shift_d = '0;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= QUIET;
      cnt_q      <= '0;
      shift_q    <= '0;
      rd_q       <= 1'b0;
      serial_q   <= 1'b0;
      k_err_q    <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rd_q       <= rd_d;
      serial_q   <= shift_d[0];
      k_err_q    <= k_err_d;
      hold_vld_q <= accept || (hold_vld_q && !take);
      if (accept) begin
        hold_q <= {i_K, i_Data};
      end
    end
  end

  assign o_Serial     = serial_q;
  assign o_Word_Start = (state_q == SHIFT) && (cnt_q == 4'd0);
  assign o_RD         = rd_q;
  assign o_K_Err      = k_err_q;

endmodule

// File: tb/tb_serializer_enc.sv
// Bench for serializer_enc: a bit-queue reference model predicts every output each cycle,
// plus directed word captures for the idle, D.0.0, D.21.5, bad-K, throughput, en-drop and reset cases.
module tb_serializer_enc;

  logic       i_Clk   = 1'b0;
  logic       i_Rst_n = 1'b0;
  logic       i_En    = 1'b0;
  logic       i_Valid = 1'b0;
  logic       i_K     = 1'b0;
  logic [7:0] i_Data  = 8'h00;
  logic       o_Ready, o_Serial, o_Word_Start, o_RD, o_K_Err;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [9:0] IDLE_RDN = 10'b0011111010;
  localparam logic [9:0] IDLE_RDP = 10'b1100000101;

  serializer_enc #(.SEND_IDLE(1'b1)) dut (
    .i_Clk        (i_Clk),
    .i_Rst_n      (i_Rst_n),
    .i_En         (i_En),
    .i_Valid      (i_Valid),
    .i_Data       (i_Data),
    .i_K          (i_K),
    .o_Ready      (o_Ready),
    .o_Serial     (o_Serial),
    .o_Word_Start (o_Word_Start),
    .o_RD         (o_RD),
    .o_K_Err      (o_K_Err)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // RD- (primary) forms of the standard sub-block tables
  logic [5:0] t6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  logic [3:0] t4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};

  // Returns {rd_after, code[9:0]}
  function automatic logic [10:0] ref_enc(input logic [7:0] d, input logic k, input logic rd);
    int x, y;
    logic [5:0] s6;
    logic [3:0] s4;
    logic r;
    bit alt;
    x = int'(d[4:0]);
    y = int'(d[7:5]);
    r = rd;
    s6 = k ? 6'b001111 : t6[x];
    alt = !k && x == 7;
    if (r && ($countones(s6) != 3 || alt)) s6 = ~s6;
    if ($countones(s6) > 3) r = 1'b1;
    else if ($countones(s6) < 3) r = 1'b0;
    if (k) s4 = 4'b0101;
    else if (y == 7 && (r ? (x == 11 || x == 13 || x == 14) : (x == 17 || x == 18 || x == 20)))
      s4 = 4'b0111;
    else s4 = t4[y];
    alt = k || y == 3;
    if (r && ($countones(s4) != 2 || alt)) s4 = ~s4;
    if ($countones(s4) > 2) r = 1'b1;
    else if ($countones(s4) < 2) r = 1'b0;
    return {r, s6, s4};
  endfunction

  // Reference model: m_q holds the line bits still to appear, m_q[0] being on the line now
  logic        m_q [$];
  logic        m_hold_vld, m_hold_k, m_rd, m_kerr, m_acc;
  logic [7:0]  m_hold_d;
  logic [10:0] m_enc;

  always @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      m_q.delete();
      m_hold_vld = 1'b0; m_hold_k = 1'b0; m_hold_d = 8'h00; m_rd = 1'b0; m_kerr = 1'b0;
    end else begin
      m_acc  = i_Valid && !m_hold_vld;
      m_kerr = 1'b0;
      if (m_q.size() > 0) void'(m_q.pop_front());
      if (m_q.size() == 0 && i_En) begin
        if (m_hold_vld) begin
          m_enc      = ref_enc(m_hold_d, m_hold_k, m_rd);
          m_kerr     = m_hold_k && (m_hold_d != 8'hBC);
          m_hold_vld = 1'b0;
        end else begin
          m_enc = ref_enc(8'hBC, 1'b1, m_rd);
        end
        m_rd = m_enc[10];
        for (int i = 0; i < 10; i++) m_q.push_back(m_enc[i]);
      end
      if (m_acc) begin
        m_hold_vld = 1'b1; m_hold_k = i_K; m_hold_d = i_Data;
      end
    end
  end

  int         cyc = 0, word_cnt = 0, cap_n = 0, last_ws = 0, prev_ws = 0, kerr_cnt = 0, ready_lo = 0;
  logic [9:0] cap_w = '0, last_word = '0;

  always @(negedge i_Clk) begin
    if (!i_Rst_n) begin
      cap_n = 0;
    end else begin
      cyc++;
      check_eq("serial", o_Serial, (m_q.size() > 0) ? m_q[0] : 1'b0);
      check_eq("word_start", o_Word_Start, m_q.size() == 10);
      check_eq("ready", o_Ready, !m_hold_vld);
      check_eq("rd", o_RD, m_rd);
      check_eq("k_err", o_K_Err, m_kerr);
      kerr_cnt += int'(o_K_Err);
      ready_lo += int'(!o_Ready);
      if (o_Word_Start) begin
        prev_ws = last_ws; last_ws = cyc;
        cap_w = '0; cap_w[0] = o_Serial; cap_n = 1;
      end else if (cap_n > 0 && cap_n < 10) begin
        cap_w[cap_n] = o_Serial;
        cap_n++;
        if (cap_n == 10) begin
          last_word = cap_w;
          word_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge i_Clk);
    #1;
  endtask

  task automatic do_reset();
    i_Rst_n = 1'b0; i_En = 1'b0; i_Valid = 1'b0; i_K = 1'b0; i_Data = 8'h00;
    tick(); tick();
    i_Rst_n = 1'b1;
  endtask

  task automatic wait_word(input string tag, output logic [9:0] w);
    int start;
    start = word_cnt;
    for (int i = 0; i < 40 && word_cnt == start; i++) tick();
    if (word_cnt == start) check_eq({tag, "_timeout"}, 0, 1);
    w = last_word;
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 40 && !o_Word_Start; i++) tick();
    if (!o_Word_Start) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  task automatic send_byte(input logic k, input logic [7:0] d);
    logic rdy;
    bit   done;
    done = 0;
    i_Valid = 1'b1; i_K = k; i_Data = d;
    for (int i = 0; i < 40 && !done; i++) begin
      rdy = o_Ready;
      tick();
      done = rdy;
    end
    if (!done) check_eq("send_timeout", 0, 1);
    i_Valid = 1'b0; i_K = 1'b0;
  endtask

  logic [9:0] w;
  logic [7:0] five [5] = '{8'h00, 8'hFF, 8'hB5, 8'hF1, 8'h47};
  int         lo1, lo2, k0, wc;

  initial begin
    tick(); tick();
    check_eq("rst_ready", o_Ready, 1);
    check_eq("rst_serial", o_Serial, 0);
    check_eq("rst_word_start", o_Word_Start, 0);
    check_eq("rst_rd", o_RD, 0);
    check_eq("rst_k_err", o_K_Err, 0);

    // Idle words after reset
    do_reset();
    i_En = 1'b1;
    wait_word("idle1", w);
    check_eq("idle1_code", w, IDLE_RDN);
    check_eq("idle1_rd", o_RD, 1);
    wait_word("idle2", w);
    check_eq("idle2_code", w, IDLE_RDP);

    // D.0.0 from RD-
    do_reset();
    send_byte(1'b0, 8'h00);
    check_eq("hold_full", o_Ready, 0);
    i_En = 1'b1;
    wait_word("d0_0", w);
    check_eq("d0_0_code", w, 10'b1001110100);
    check_eq("d0_0_rd", o_RD, 0);

    // D.21.5 from RD+, accepted on the same edge the idle word loads
    do_reset();
    i_En = 1'b1;
    send_byte(1'b0, 8'hB5);
    wait_word("d21_5_pre", w);
    wait_word("d21_5", w);
    check_eq("d21_5_code", w, 10'b1010101010);
    check_eq("d21_5_rd", o_RD, 1);

    // Unsupported K request
    do_reset();
    send_byte(1'b1, 8'h3C);
    k0 = kerr_cnt;
    i_En = 1'b1;
    wait_word("kbad", w);
    check_eq("kbad_code", w, IDLE_RDN);
    wait_word("kbad_next", w);
    check_eq("kbad_pulses", kerr_cnt - k0, 1);

    // Back-to-back throughput
    do_reset();
    i_En = 1'b1;
    lo1 = 0;
    for (int j = 0; j < 5; j++) begin
      send_byte(1'b0, five[j]);
      if (j == 1) lo1 = ready_lo;
    end
    lo2 = ready_lo;
    check_eq("ready_low_30cyc", lo2 - lo1, 27);
    wait_word("b2b_a", w);
    wait_word("b2b_b", w);
    check_eq("ws_period", last_ws - prev_ws, 10);

    // En dropped mid-word
    do_reset();
    i_En = 1'b1;
    wait_start("endrop");
    repeat (4) tick();
    i_En = 1'b0;
    wait_word("endrop", w);
    check_eq("endrop_code", w, IDLE_RDN);
    tick();
    check_eq("endrop_serial", o_Serial, 0);
    check_eq("endrop_ws", o_Word_Start, 0);
    wc = word_cnt;
    repeat (15) tick();
    check_eq("endrop_quiet", word_cnt, wc);

    // Reset at count 6 with a byte held
    do_reset();
    i_En = 1'b1;
    wait_start("midrst");
    send_byte(1'b0, 8'h55);
    repeat (5) tick();
    check_eq("midrst_pre_serial", o_Serial, 1);
    check_eq("midrst_pre_ready", o_Ready, 0);
    #2;
    i_Rst_n = 1'b0;
    i_En = 1'b0;
    #1;
    check_eq("midrst_serial", o_Serial, 0);
    check_eq("midrst_ready", o_Ready, 1);
    check_eq("midrst_ws", o_Word_Start, 0);
    check_eq("midrst_rd", o_RD, 0);
    tick();
    i_Rst_n = 1'b1;
    tick();
    i_En = 1'b1;
    wait_word("midrst_after", w);
    check_eq("midrst_discard", w, IDLE_RDN);

    // Every data byte, back to back
    do_reset();
    i_En = 1'b1;
    for (int v = 0; v < 256; v++) send_byte(1'b0, 8'(v));

    // Random traffic with occasional en toggles and K requests
    do_reset();
    i_En = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(63) == 0) i_En = !i_En;
      i_Valid = 1'($urandom_range(1));
      i_K     = ($urandom_range(7) == 0);
      i_Data  = (i_K && $urandom_range(1) == 1) ? 8'hBC : 8'($urandom);
      tick();
    end
    i_Valid = 1'b0;
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
